// File: rtl/mul_bcd_seq.sv
// Sequential 4x4 unsigned shift-add multiplier followed by an 8-step
// double-dabble binary-to-BCD conversion. One operation takes 13 busy
// cycles (4 MUL, 8 BCD, 1 DONE); the product and digits are held until
// the next completion.
module mul_bcd_seq (
   input  logic       fclk,
   input  logic       clr,
   input  logic       start,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       busy,
   output logic       done,
   output logic [7:0] product,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMul  = 2'd1;
   localparam logic [1:0] StBcd  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]  state;
   logic [3:0]  mcand;
   logic [3:0]  mplier;
   logic [7:0]  acc;
   logic [2:0]  step;
   logic [7:0]  shift;
   logic [11:0] bcd;

   logic [7:0]  acc_next;
   logic [11:0] bcd_adj;
   logic [11:0] bcd_next;
   logic [7:0]  shift_next;

   // Accumulator after this MUL step, so the final partial product is
   // included when the value is handed to the BCD stage.
   always_comb begin
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + ({4'b0000, mcand} << step);
      end
   end

   // One double-dabble step: correct nibbles >= 5, then shift left by one.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      {bcd_next, shift_next} = {bcd_adj[10:0], shift, 1'b0};
   end

   // Status decoded straight from the state register.
   always_comb begin
      busy = (state != StIdle);
      done = (state == StDone);
   end

   // Control FSM and datapath registers.
   always_ff @(posedge fclk or posedge clr) begin
      if (clr) begin
         state    <= StIdle;
         mcand    <= 4'd0;
         mplier   <= 4'd0;
         acc      <= 8'd0;
         step     <= 3'd0;
         shift    <= 8'd0;
         bcd      <= 12'd0;
         product  <= 8'd0;
         ones     <= 4'd0;
         tens     <= 4'd0;
         hundreds <= 4'd0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= 8'd0;
                  step   <= 3'd0;
                  state  <= StMul;
               end
            end
            StMul: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               step   <= step + 3'd1;
               if (step == 3'd3) begin
                  shift <= acc_next;
                  bcd   <= 12'd0;
                  step  <= 3'd0;
                  state <= StBcd;
               end
            end
            StBcd: begin
               bcd   <= bcd_next;
               shift <= shift_next;
               step  <= step + 3'd1;
               if (step == 3'd7) begin
                  product  <= acc;
                  hundreds <= bcd_next[11:8];
                  tens     <= bcd_next[7:4];
                  ones     <= bcd_next[3:0];
                  state    <= StDone;
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_bcd_seq.sv
// Directed bench for mul_bcd_seq. Inputs change on the falling edge or just
// after a rising edge; outputs are sampled on the falling edge.
module tb_mul_bcd_seq;

   logic       fclk;
   logic       clr;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [3:0] hundreds;

   int vectors = 0;
   int misses  = 0;
   int cyc     = 0;

   mul_bcd_seq dut (
      .fclk     (fclk),
      .clr      (clr),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .ones     (ones),
      .tens     (tens),
      .hundreds (hundreds)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   always @(posedge fclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         misses++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Counts falling edges until done is seen (bounded); lat=0 on timeout.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge fclk);
         if (busy) bcnt++;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   // Present operands with a one-cycle start pulse captured at the next edge.
   task automatic launch(input logic [3:0] av, input logic [3:0] bv);
      @(negedge fclk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge fclk);
      #1 start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input int exp_p, input int exp_h, input int exp_t, input int exp_o);
      int lat, bcnt;
      launch(av, bv);
      wait_done(lat, bcnt);
      // done shows in the 13th cycle after the capture edge
      check({tag, "_latency"}, lat, 13);
      check({tag, "_busy_cycles"}, bcnt, 13);
      check({tag, "_product"}, product, exp_p);
      check({tag, "_hundreds"}, hundreds, exp_h);
      check({tag, "_tens"}, tens, exp_t);
      check({tag, "_ones"}, ones, exp_o);
      @(negedge fclk);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_idle_after"}, busy, 0);
   endtask

   initial begin
      int lat, bcnt, ndone, got, last_cyc;
      logic [7:0] exp_p;
      clr   = 1'b1;
      start = 1'b0;
      a     = 4'd0;
      b     = 4'd0;
      repeat (3) @(negedge fclk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_product", product, 0);
      check("reset_digits", {hundreds, tens, ones}, 0);
      clr = 1'b0;
      repeat (2) @(negedge fclk);
      check("idle_no_start", busy, 0);

      run_op("m15x15", 4'd15, 4'd15, 225, 2, 2, 5);
      run_op("m13x11", 4'd13, 4'd11, 143, 1, 4, 3);
      run_op("m0x9", 4'd0, 4'd9, 0, 0, 0, 0);
      run_op("m9x0", 4'd9, 4'd0, 0, 0, 0, 0);

      // Starts while busy are ignored and operand changes have no effect.
      launch(4'd7, 4'd6);
      ndone = 0;
      got   = 0;
      lat   = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge fclk);
         if (done) begin
            ndone++;
            got = product;
            lat = k;
         end
         if (k == 2 || k == 7) begin
            start = 1'b1;
            a     = 4'd15;
            b     = 4'd15;
         end else begin
            start = 1'b0;
         end
      end
      check("ignore_start_latency", lat, 13);
      check("ignore_start_ndone", ndone, 1);
      check("ignore_start_product", got, 42);
      check("ignore_start_digits", {hundreds, tens, ones}, 12'h042);
      check("hold_product", product, 42);

      // Abort in the BCD phase.
      launch(4'd15, 4'd15);
      repeat (7) @(negedge fclk);
      check("pre_abort_busy", busy, 1);
      clr = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_product", product, 0);
      check("abort_digits", {hundreds, tens, ones}, 0);
      @(negedge fclk);
      clr   = 1'b0;
      ndone = 0;
      bcnt  = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge fclk);
         if (done) ndone++;
         if (busy) bcnt++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_stays_idle", bcnt, 0);
      run_op("m3x5", 4'd3, 4'd5, 15, 0, 1, 5);

      // Exhaustive sweep with start held high.
      @(negedge fclk);
      a        = 4'd0;
      b        = 4'd0;
      start    = 1'b1;
      last_cyc = 0;
      for (int i = 0; i < 256; i++) begin
         exp_p = 8'(i / 16) * 8'(i % 16);
         wait_done(lat, bcnt);
         check("sweep_done_seen", (lat != 0), 1);
         check("sweep_product", product, exp_p);
         check("sweep_digits", {hundreds, tens, ones},
               {4'(exp_p / 100), 4'((exp_p / 10) % 10), 4'(exp_p % 10)});
         if (i > 0) check("sweep_spacing", cyc - last_cyc, 14);
         last_cyc = cyc;
         if (i < 255) begin
            a = 4'((i + 1) / 16);
            b = 4'((i + 1) % 16);
         end
      end
      start = 1'b0;
      repeat (16) @(negedge fclk);
      check("sweep_end_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
